fir_seq_mac: RTL and testbench

Parametrised, time-multiplexed FIR filter for the audio-classification front end. It succeeds the fixed 8-tap parallel filter with a configurable tap count, runtime-loadable coefficients, a valid/ready input handshake, and a rounded, shifted output. A single multiplier-accumulator iterates over the taps, so area does not grow with NTAPS. The block sits between the sample source and the feature-extraction stage.

---
 rtl/fir_seq_mac.sv | 207 ++++++++++++++++++++
 tb/tb_fir_seq_mac.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_mac.sv
// ---------------------------------------------------------------------------
// fir_seq_mac
//
// Time-multiplexed FIR filter. A single multiplier-accumulator walks over the
// taps one per cycle, so the datapath stays the same size for any NTAPS.
//   y[n] = sum_{k=0}^{NTAPS-1} c[k] * x[n-k]   (c[0] multiplies the newest sample)
//
// Optional feature macro: FIR_SAT_EN
//   defined   -> output is clamped to the OUT_W signed range, out_sat flags it
//   undefined -> output wraps (low OUT_W bits), out_sat is tied to 0
//
// Ports
//   CLK         rising-edge clock
//   RST_N       asynchronous active-low reset (delay line 0, c[0]=1, others 0)
//   clr         synchronous flush: zero delay line, abort sample, keep coefs
//   in_data     signed input sample (DATA_W)
//   in_valid    sample offered
//   in_ready    block is idle and can accept a sample
//   coef_we     coefficient write strobe (honoured only while idle)
//   coef_addr   tap index of the write (clog2(NTAPS) bits)
//   coef_wdata  signed coefficient (COEF_W)
//   out_data    signed filtered sample (OUT_W), held between pulses
//   out_valid   one-cycle pulse marking a new out_data
//   out_sat     saturation flag for this out_data, qualified by out_valid
// ---------------------------------------------------------------------------
module fir_seq_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      clr,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      coef_we,
  input  logic [$clog2(NTAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_valid,
  output logic                      out_sat
);

  localparam int AW = $clog2(NTAPS);
  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NTAPS - 1);
  localparam logic [AW:0]   NTAPS_LIM = (AW + 1)'(NTAPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] xline [NTAPS];
  logic signed [COEF_W-1:0] coef  [NTAPS];
  logic        [AW-1:0]     idx;
  logic signed [ACC_W-1:0]  acc;

  logic                     accept;
  logic                     last_term;
  logic                     coef_ok;
  logic signed [PW-1:0]     x_ext;
  logic signed [PW-1:0]     c_ext;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W:0]    r;
  logic signed [OUT_W-1:0]  out_nxt;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign last_term = (idx == LAST_IDX);

  // Non-power-of-two tap counts leave addresses above NTAPS-1 that must be ignored.
  assign coef_ok = coef_we && (state == S_IDLE) && ({1'b0, coef_addr} < NTAPS_LIM);

  // Size casts keep the signedness, so both operands are sign-extended to the
  // full product width before the multiply.
  assign x_ext    = PW'(xline[idx]);
  assign c_ext    = PW'(coef[idx]);
  assign prod     = x_ext * c_ext;
  assign prod_ext = ACC_W'(prod);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clr overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_MAC;
      S_MAC:   if (last_term) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (clr) begin
      state_nxt = S_IDLE;
    end
  end

  // Delay line, coefficient bank and accumulator. Coefficients survive clr but
  // go back to the identity filter on reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NTAPS; k++) begin
        xline[k] <= '0;
        coef[k]  <= (k == 0) ? COEF_W'(1) : '0;
      end
      idx <= '0;
      acc <= '0;
    end else if (clr) begin
      for (int k = 0; k < NTAPS; k++) begin
        xline[k] <= '0;
      end
    end else begin
      if (accept) begin
        xline[0] <= in_data;
        for (int k = 1; k < NTAPS; k++) begin
          xline[k] <= xline[k-1];
        end
        acc <= '0;
        idx <= '0;
      end
      if (state == S_MAC) begin
        acc <= acc + prod_ext;
        idx <= idx + 1'b1;
      end
      if (coef_ok) begin
        coef[coef_addr] <= coef_wdata;
      end
    end
  end

  // Round-half-up before the arithmetic shift; one guard bit keeps the
  // rounding add from overflowing.
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
      assign r = ($signed({acc[ACC_W-1], acc}) + HALF) >>> SHIFT;
    end else begin : g_noround
      assign r = {acc[ACC_W-1], acc};
    end
  endgenerate

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic sat_hi;
  logic sat_lo;

  assign sat_hi  = (r > SAT_MAX);
  assign sat_lo  = (r < SAT_MIN);
  assign out_nxt = sat_hi ? SAT_MAX[OUT_W-1:0] :
                   sat_lo ? SAT_MIN[OUT_W-1:0] : r[OUT_W-1:0];

  // Output register with saturation flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (!clr && (state == S_OUT)) begin
        out_data  <= out_nxt;
        out_valid <= 1'b1;
        out_sat   <= sat_hi || sat_lo;
      end
    end
  end
`else
  // Wrap-around narrowing; the discarded high bits are folded into a sink.
  logic unused_r_high;

  assign out_nxt       = r[OUT_W-1:0];
  assign unused_r_high = ^r[ACC_W:OUT_W];
  assign out_sat       = 1'b0;

  // Output register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (!clr && (state == S_OUT)) begin
        out_data  <= out_nxt;
        out_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fir_seq_mac.sv
// ---------------------------------------------------------------------------
// tb_fir_seq_mac
//
// Directed bench for fir_seq_mac. Main instance uses the default parameters
// (NTAPS=8, SHIFT=0); a second instance with NTAPS=5 has spare address codes
// so out-of-range coefficient writes can be exercised.
// ---------------------------------------------------------------------------
module tb_fir_seq_mac;

  localparam int NTAPS  = 8;
  localparam int NTAPS2 = 5;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               clr = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [7:0]  coef_wdata = '0;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_sat;

  logic               clr2 = 1'b0;
  logic signed [15:0] in2_data = '0;
  logic               in2_valid = 1'b0;
  logic               in2_ready;
  logic               coef2_we = 1'b0;
  logic [2:0]         coef2_addr = '0;
  logic signed [7:0]  coef2_wdata = '0;
  logic signed [15:0] out2_data;
  logic               out2_valid;
  logic               out2_sat;

  typedef struct {
    string              name;
    logic signed [15:0] din;
    logic signed [15:0] expOut;
    logic               expSat;
  } vec_t;

  vec_t idTab[$];
  vec_t impTab[$];
  vec_t busyTab[$];
  vec_t satTab[$];
  vec_t clrTab[$];
  vec_t rstTab[$];

  int vecCount  = 0;
  int missCount = 0;

  always #5 CLK = ~CLK;

  fir_seq_mac #(
    .DATA_W(16), .COEF_W(8), .NTAPS(NTAPS), .ACC_W(32), .OUT_W(16), .SHIFT(0)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_data(out_data), .out_valid(out_valid), .out_sat(out_sat)
  );

  fir_seq_mac #(
    .DATA_W(16), .COEF_W(8), .NTAPS(NTAPS2), .ACC_W(32), .OUT_W(16), .SHIFT(0)
  ) dut2 (
    .CLK(CLK), .RST_N(RST_N), .clr(clr2),
    .in_data(in2_data), .in_valid(in2_valid), .in_ready(in2_ready),
    .coef_we(coef2_we), .coef_addr(coef2_addr), .coef_wdata(coef2_wdata),
    .out_data(out2_data), .out_valid(out2_valid), .out_sat(out2_sat)
  );

  // Single comparison point: every check steps vecCount, misses step missCount.
  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Offers one sample, waits for its result and reports edges from accept to out_valid.
  task automatic applyStimulus(input logic signed [15:0] d, input bit busyWrite,
                               output logic signed [15:0] got, output logic gotSat,
                               output int lat);
    int n;
    @(negedge CLK);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) checkOutput("ready_timeout", 0, 1);
    @(posedge CLK);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge CLK);
      #1 lat++;
      if (busyWrite && lat == 3) begin
        coef_we    = 1'b1;
        coef_addr  = 3'd0;
        coef_wdata = 8'sd99;
      end
      if (lat == 4) coef_we = 1'b0;
      if (out_valid) break;
    end
    coef_we = 1'b0;
    got     = out_data;
    gotSat  = out_sat;
  endtask

  task automatic runTable(input vec_t tbl[$], input bit busyFirst);
    logic signed [15:0] got;
    logic               gotSat;
    int                 lat;
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].din, busyFirst && (i == 0), got, gotSat, lat);
      checkOutput({tbl[i].name, "_data"}, got, tbl[i].expOut);
      checkOutput({tbl[i].name, "_sat"}, gotSat, tbl[i].expSat);
      checkOutput({tbl[i].name, "_lat"}, lat, NTAPS + 1);
      @(posedge CLK);
      #1 checkOutput({tbl[i].name, "_pulse"}, out_valid, 0);
      checkOutput({tbl[i].name, "_hold"}, out_data, tbl[i].expOut);
    end
  endtask

  task automatic loadCoef(input logic [2:0] a, input logic signed [7:0] v);
    @(negedge CLK);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    @(posedge CLK);
    #1 coef_we = 1'b0;
  endtask

  task automatic clrPulse();
    @(negedge CLK);
    clr = 1'b1;
    @(posedge CLK);
    #1 clr = 1'b0;
  endtask

  function automatic vec_t mk(input string name, input int din, input int expOut, input bit expSat);
    vec_t v;
    v.name   = name;
    v.din    = 16'(din);
    v.expOut = 16'(expOut);
    v.expSat = expSat;
    return v;
  endfunction

  task automatic sendSample2(input logic signed [15:0] d, input int expOut, input string name);
    int lat;
    @(negedge CLK);
    in2_data  = d;
    in2_valid = 1'b1;
    checkOutput({name, "_ready"}, in2_ready, 1);
    @(posedge CLK);
    #1 in2_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge CLK);
      #1 lat++;
      if (out2_valid) break;
    end
    checkOutput({name, "_lat"}, lat, NTAPS2 + 1);
    checkOutput({name, "_data"}, out2_data, expOut);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic signed [15:0] hsIn [3];
    logic signed [15:0] hsExp[3];
    int acceptCyc[$];
    int lowRuns[$];
    int lowRun, sent, gotN, cyc, seen;

    // Vector tables, all expected values worked out by hand.
    idTab.push_back(mk("id0", 100, 100, 0));
    idTab.push_back(mk("id1", -200, -200, 0));
    idTab.push_back(mk("id2", 300, 300, 0));

    impTab.push_back(mk("imp0", 100, 200, 0));
    impTab.push_back(mk("imp1", 0, -100, 0));
    impTab.push_back(mk("imp2", 0, -400, 0));
    impTab.push_back(mk("imp3", 0, 800, 0));
    impTab.push_back(mk("imp4", 0, 800, 0));
    impTab.push_back(mk("imp5", 0, -400, 0));
    impTab.push_back(mk("imp6", 0, -100, 0));
    impTab.push_back(mk("imp7", 0, 200, 0));

    busyTab.push_back(mk("busy0", 100, 200, 0));
    busyTab.push_back(mk("busy1", 0, -100, 0));
    busyTab.push_back(mk("busy2", 50, -300, 0));

    // n * 127 * 32767 = n * 0x3F7F81; wrapped low halves 0x7F81, 0xFF02, 0x7E83.
`ifdef FIR_SAT_EN
    satTab.push_back(mk("sat0", 32767, 32767, 1));
    satTab.push_back(mk("sat1", 32767, 32767, 1));
    satTab.push_back(mk("sat2", 32767, 32767, 1));
`else
    satTab.push_back(mk("sat0", 32767, 32641, 0));
    satTab.push_back(mk("sat1", 32767, -254, 0));
    satTab.push_back(mk("sat2", 32767, 32387, 0));
`endif

    clrTab.push_back(mk("clr0", 100, 12700, 0));
    clrTab.push_back(mk("clr1", 50, 19050, 0));

    rstTab.push_back(mk("rst0", 77, 77, 0));
    rstTab.push_back(mk("rst1", 5, 5, 0));

    hsIn  = '{16'sd100, 16'sd0, 16'sd0};
    hsExp = '{16'sd200, -16'sd100, -16'sd400};

    // Reset state.
    #12;
    checkOutput("reset_ready", in_ready, 1);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_data", out_data, 0);
    checkOutput("reset_sat", out_sat, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    runTable(idTab, 1'b0);

    loadCoef(3'd0, 8'sd2);
    loadCoef(3'd1, -8'sd1);
    loadCoef(3'd2, -8'sd4);
    loadCoef(3'd3, 8'sd8);
    loadCoef(3'd4, 8'sd8);
    loadCoef(3'd5, -8'sd4);
    loadCoef(3'd6, -8'sd1);
    loadCoef(3'd7, 8'sd2);
    clrPulse();
    runTable(impTab, 1'b0);

    // A write to c[0] lands mid-MAC of the first sample and must be ignored.
    clrPulse();
    runTable(busyTab, 1'b1);

    // Back-to-back offers with in_valid held high.
    clrPulse();
    lowRun = 0;
    sent   = 0;
    gotN   = 0;
    cyc    = 0;
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = hsIn[0];
    while (gotN < 3 && cyc < 100) begin
      if (out_valid) begin
        checkOutput($sformatf("hs_out%0d", gotN), out_data, hsExp[gotN]);
        gotN++;
      end
      if (in_ready) begin
        if (lowRun > 0) lowRuns.push_back(lowRun);
        lowRun = 0;
      end else begin
        lowRun++;
      end
      if (in_ready && in_valid) begin
        acceptCyc.push_back(cyc);
        sent++;
      end
      @(posedge CLK);
      #1;
      if (sent >= 3) in_valid = 1'b0;
      else in_data = hsIn[sent];
      @(negedge CLK);
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("hs_outputs", gotN, 3);
    checkOutput("hs_accepts", acceptCyc.size(), 3);
    checkOutput("hs_low_runs", lowRuns.size(), 3);
    for (int i = 1; i < acceptCyc.size(); i++)
      checkOutput($sformatf("hs_spacing%0d", i), acceptCyc[i] - acceptCyc[i-1], NTAPS + 2);
    foreach (lowRuns[i])
      checkOutput($sformatf("hs_low%0d", i), lowRuns[i], NTAPS + 1);

    // Saturation / wrap with every coefficient at 127.
    for (int k = 0; k < NTAPS; k++) loadCoef(3'(k), 8'sd127);
    clrPulse();
    runTable(satTab, 1'b0);

    // clr during MAC: no result, idle next cycle, history wiped.
    @(negedge CLK);
    in_data  = 16'sd1000;
    in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    clr = 1'b1;
    @(posedge CLK);
    #1 clr = 1'b0;
    checkOutput("clr_ready", in_ready, 1);
    seen = 0;
    repeat (NTAPS + 4) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    checkOutput("clr_no_valid", seen, 0);
    runTable(clrTab, 1'b0);

    // Reset in the middle of a MAC.
    @(negedge CLK);
    in_data  = 16'sd500;
    in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("rst_mid_data", out_data, 0);
    checkOutput("rst_mid_valid", out_valid, 0);
    checkOutput("rst_mid_ready", in_ready, 1);
    checkOutput("rst_mid_sat", out_sat, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    runTable(rstTab, 1'b0);

    // Out-of-range writes on the 5-tap instance, plus one legal write to c[1].
    @(negedge CLK);
    coef2_we    = 1'b1;
    coef2_addr  = 3'd5;
    coef2_wdata = 8'sd50;
    @(negedge CLK);
    coef2_addr  = 3'd7;
    @(negedge CLK);
    coef2_addr  = 3'd1;
    coef2_wdata = 8'sd3;
    @(negedge CLK);
    coef2_we    = 1'b0;
    sendSample2(16'sd10, 10, "oor0");
    sendSample2(16'sd20, 50, "oor1");
    sendSample2(16'sd0, 60, "oor2");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
